// File: rtl/ev21g1_pkg.sv
// Shared opcode/shift encodings and microinstruction field layout for the ev21g1 execute pipe.
package ev21g1_pkg;

   localparam logic [3:0] ALU_PASS_A = 4'b0000;
   localparam logic [3:0] ALU_PASS_B = 4'b0001;
   localparam logic [3:0] ALU_NOT_B  = 4'b0011;
   localparam logic [3:0] ALU_ADD    = 4'b0100;
   localparam logic [3:0] ALU_ADC    = 4'b0101;
   localparam logic [3:0] ALU_OR     = 4'b0110;
   localparam logic [3:0] ALU_AND    = 4'b0111;
   localparam logic [3:0] ALU_XOR    = 4'b1000;
   localparam logic [3:0] ALU_SUB    = 4'b1001;
   localparam logic [3:0] ALU_CLC    = 4'b1011;
   localparam logic [3:0] ALU_STC    = 4'b1100;

   localparam logic [2:0] SH_NONE  = 3'b000;
   localparam logic [2:0] SH_SHL1  = 3'b001;
   localparam logic [2:0] SH_LSR1  = 3'b010;
   localparam logic [2:0] SH_SHL_H = 3'b011;
   localparam logic [2:0] SH_LSR_H = 3'b100;
   localparam logic [2:0] SH_ROL1  = 3'b101;
   localparam logic [2:0] SH_ROR1  = 3'b110;
   localparam logic [2:0] SH_ASR1  = 3'b111;

   // read/write are 2-bit memory-control fields owned by the wrapper, which brings the word to 14+3*aw.
   function automatic int ui_w(input int aw);      return 14 + 3*aw; endfunction
   function automatic int off_print(input int aw); return 0 * aw;    endfunction
   function automatic int off_flip(input int aw);  return 1 + 0*aw;  endfunction
   function automatic int off_c(input int aw);     return 2 + 0*aw;  endfunction
   function automatic int off_b(input int aw);     return 2 + aw;    endfunction
   function automatic int off_a(input int aw);     return 2 + 2*aw;  endfunction
   function automatic int off_write(input int aw); return 2 + 3*aw;  endfunction
   function automatic int off_read(input int aw);  return 4 + 3*aw;  endfunction
   function automatic int off_kmx(input int aw);   return 6 + 3*aw;  endfunction
   function automatic int off_sh(input int aw);    return 7 + 3*aw;  endfunction
   function automatic int off_aluc(input int aw);  return 10 + 3*aw; endfunction

   function automatic logic is_null_addr(input logic [15:0] addr, input int aw);
      return addr == 16'((32'd1 << aw) - 32'd1);
   endfunction

   function automatic logic alu_writes(input logic [3:0] op);
      case (op)
         ALU_PASS_A, ALU_PASS_B, ALU_NOT_B, ALU_ADD, ALU_ADC,
         ALU_OR, ALU_AND, ALU_XOR, ALU_SUB: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic alu_valid(input logic [3:0] op);
      return alu_writes(op) || (op == ALU_CLC) || (op == ALU_STC);
   endfunction

endpackage

// File: rtl/ev21g1_exec_pipe_if.sv
// Microinstruction/constant inputs and print/carry outputs of the execute pipe.
interface ev21g1_exec_pipe_if
   import ev21g1_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 6,
   parameter int K_W        = DATA_W/2
);
   localparam int UI_W = ui_w(REG_ADDR_W);

   logic [K_W-1:0]    k;
   logic [UI_W-1:0]   uinstr;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              cy;

   modport master (output k, uinstr, input out_data, out_valid, cy);
   modport slave  (input k, uinstr, output out_data, out_valid, cy);
endinterface

// File: rtl/ev21g1_alu_shift.sv
// Combinational ALU followed by shifter; cy_o is the next carry value (equals cy_i when untouched).
// No state, no backpressure.
module ev21g1_alu_shift
   import ev21g1_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [3:0]        aluc_i,
   input  logic [2:0]        sh_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic              cy_i,
   output logic [DATA_W-1:0] res_o,
   output logic              cy_o
);
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu;

   always_comb begin
      sum  = '0;
      alu  = '0;
      cy_o = cy_i;
      case (aluc_i)
         ALU_PASS_A: alu = a_i;
         ALU_PASS_B: alu = b_i;
         ALU_NOT_B:  alu = ~b_i;
         ALU_ADD: begin
            sum  = {1'b0, a_i} + {1'b0, b_i};
            alu  = sum[DATA_W-1:0];
            cy_o = sum[DATA_W];
         end
         ALU_ADC: begin
            sum  = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cy_i};
            alu  = sum[DATA_W-1:0];
            cy_o = sum[DATA_W];
         end
         ALU_OR:  alu = a_i | b_i;
         ALU_AND: alu = a_i & b_i;
         ALU_XOR: alu = a_i ^ b_i;
         // the wrapped top bit of the extended difference is the borrow
         ALU_SUB: begin
            sum  = {1'b0, a_i} - {1'b0, b_i};
            alu  = sum[DATA_W-1:0];
            cy_o = sum[DATA_W];
         end
         ALU_CLC: cy_o = 1'b0;
         ALU_STC: cy_o = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      res_o = alu;
      case (sh_i)
         SH_SHL1:  res_o = alu << 1;
         SH_LSR1:  res_o = alu >> 1;
         SH_SHL_H: res_o = alu << (DATA_W/2);
         SH_LSR_H: res_o = alu >> (DATA_W/2);
         SH_ROL1:  res_o = {alu[DATA_W-2:0], alu[DATA_W-1]};
         SH_ROR1:  res_o = {alu[0], alu[DATA_W-1:1]};
         SH_ASR1:  res_o = {alu[DATA_W-1], alu[DATA_W-1:1]};
         default:  res_o = alu;
      endcase
   end
endmodule

// File: rtl/ev21g1_exec_pipe.sv
// Read/execute/writeback pipe with S1/S2 operand bypass; regfile write and print land 2 edges after issue.
// Accepts one microinstruction every cycle, no backpressure.
module ev21g1_exec_pipe
   import ev21g1_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 6,
   parameter int K_W        = DATA_W/2,
   parameter int FORWARD_EN = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   ev21g1_exec_pipe_if.slave pipe_io
);
   localparam int NREG    = 2**REG_ADDR_W;
   localparam int O_PRINT = off_print(REG_ADDR_W);
   localparam int O_FLIP  = off_flip(REG_ADDR_W);
   localparam int O_C     = off_c(REG_ADDR_W);
   localparam int O_B     = off_b(REG_ADDR_W);
   localparam int O_A     = off_a(REG_ADDR_W);
   localparam int O_WRITE = off_write(REG_ADDR_W);
   localparam int O_READ  = off_read(REG_ADDR_W);
   localparam int O_KMX   = off_kmx(REG_ADDR_W);
   localparam int O_SH    = off_sh(REG_ADDR_W);
   localparam int O_ALUC  = off_aluc(REG_ADDR_W);
   localparam bit FWD     = (FORWARD_EN != 0);

   typedef logic [REG_ADDR_W-1:0] ra_t;
   typedef logic [DATA_W-1:0]     dw_t;

   logic [3:0] op_s0;
   logic [2:0] sh_s0;
   logic       kmx_s0, prt_s0;
   ra_t        a_s0, b_s0, c_s0;
   logic       unused_fields;

   assign op_s0  = pipe_io.uinstr[O_ALUC +: 4];
   assign sh_s0  = pipe_io.uinstr[O_SH +: 3];
   assign kmx_s0 = pipe_io.uinstr[O_KMX];
   assign a_s0   = pipe_io.uinstr[O_A +: REG_ADDR_W];
   assign b_s0   = pipe_io.uinstr[O_B +: REG_ADDR_W];
   assign c_s0   = pipe_io.uinstr[O_C +: REG_ADDR_W];
   assign prt_s0 = pipe_io.uinstr[O_PRINT];
   assign unused_fields = ^{pipe_io.uinstr[O_READ +: 2], pipe_io.uinstr[O_WRITE +: 2],
                            pipe_io.uinstr[O_FLIP]};

   dw_t        rf_q [NREG];
   logic       s1_vld_q, s1_wr_q, s1_prt_q;
   logic [3:0] s1_op_q;
   logic [2:0] s1_sh_q;
   ra_t        s1_c_q;
   dw_t        s1_a_q, s1_b_q;
   logic       s2_wr_q, s2_prt_q;
   ra_t        s2_c_q;
   dw_t        s2_res_q;
   logic       cy_q;
   dw_t        out_data_q;
   logic       out_valid_q;
   dw_t        alu_res;
   logic       alu_cy;
   dw_t        opa_d, opb_d;

   ev21g1_alu_shift #(.DATA_W(DATA_W)) u_alu (
      .aluc_i (s1_op_q),
      .sh_i   (s1_sh_q),
      .a_i    (s1_a_q),
      .b_i    (s1_b_q),
      .cy_i   (cy_q),
      .res_o  (alu_res),
      .cy_o   (alu_cy)
   );

   // s*_wr_q already excludes the null sink, so a null source can never hit a bypass.
   always_comb begin
      opa_d = rf_q[a_s0];
      if (FWD && s1_wr_q && (s1_c_q == a_s0))      opa_d = alu_res;
      else if (FWD && s2_wr_q && (s2_c_q == a_s0)) opa_d = s2_res_q;
      if (kmx_s0) opa_d = DATA_W'(pipe_io.k);

      opb_d = rf_q[b_s0];
      if (FWD && s1_wr_q && (s1_c_q == b_s0))      opb_d = alu_res;
      else if (FWD && s2_wr_q && (s2_c_q == b_s0)) opb_d = s2_res_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q    <= 1'b0;
         s1_wr_q     <= 1'b0;
         s1_prt_q    <= 1'b0;
         s1_op_q     <= '0;
         s1_sh_q     <= '0;
         s1_c_q      <= '0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s2_wr_q     <= 1'b0;
         s2_prt_q    <= 1'b0;
         s2_c_q      <= '0;
         s2_res_q    <= '0;
         cy_q        <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         s1_vld_q <= alu_valid(op_s0);
         s1_wr_q  <= alu_writes(op_s0) && !is_null_addr(16'(c_s0), REG_ADDR_W);
         s1_prt_q <= prt_s0 && alu_writes(op_s0);
         s1_op_q  <= op_s0;
         s1_sh_q  <= sh_s0;
         s1_c_q   <= c_s0;
         s1_a_q   <= opa_d;
         s1_b_q   <= opb_d;

         s2_wr_q  <= s1_wr_q;
         s2_prt_q <= s1_prt_q;
         s2_c_q   <= s1_c_q;
         s2_res_q <= alu_res;
         if (s1_vld_q) cy_q <= alu_cy;

         out_valid_q <= s2_prt_q;
         if (s2_prt_q) out_data_q <= s2_res_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (s2_wr_q) begin
         rf_q[s2_c_q] <= s2_res_q;
      end
   end

   assign pipe_io.out_data  = out_data_q;
   assign pipe_io.out_valid = out_valid_q;
   assign pipe_io.cy        = cy_q;
endmodule

// File: doc/ev21g1_exec_pipe.md
Name: ev21g1_exec_pipe

Overview:
Parametrised successor of the ev21g1 register-file/ALU data path: a 3-stage pipeline (read, execute, writeback) driven by one packed microinstruction per cycle.
- Adds operand forwarding, so dependent microinstructions issue back-to-back without flush NOPs.
- Adds XOR/SUB ALU ops, extended shifter modes, a null destination and a registered print output port.
- Sits between the microsequencer and the memory/IO wrapper. Memory read/write and flip fields pass through unused (handled outside this block).

Parameters:
DATA_W, 32, datapath and register width (even, >=8)
REG_ADDR_W, 6, register address width; 2**REG_ADDR_W registers, all-ones address = null sink
K_W, DATA_W/2, constant field width, zero-extended to DATA_W
FORWARD_EN, 1, 1 = bypass enabled; 0 = legacy timing, software inserts 2 NOPs between dependent ops

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
k  in  K_W  constant operand
uinstr  in  UI_W (=14+3*REG_ADDR_W)  {aluc[3:0], sh[2:0], kmx, read, write, a, b, c, flip, print}, MSB first
out_data  out  DATA_W  last printed result
out_valid  out  1  one-cycle pulse when out_data updates
cy  out  1  carry flag

Behaviour:
Reset (async, rst_n=0):
- All registers = 0, CY = 0, pipeline valid bits = 0, out_data = 0, out_valid = 0.
- Reset mid-operation discards in-flight ops; no write completes after rst_n falls.

Stage timing (uinstr presented in cycle N):
- S0, cycle N: decode. A' = kmx ? zext(k) : R[a]; B = R[b]. Both latched at edge E0.
- S1, cycle N+1: ALU then shifter. Result latched at E1. CY updated at E1.
- S2, cycle N+2: R[c] written at E2 unless c is all-ones or the op is non-writing. When print=1: out_data <= result and out_valid=1 for the cycle after E2.

Forwarding (FORWARD_EN=1), for each S0 operand address:
- Match on valid writing S1 dest uses the S1 combinational result (highest priority).
- Else match on S2 dest uses the S2 result.
- Else the regfile.
- kmx=1 suppresses forwarding on A'.
- Null address (all-ones) never matches.
- FORWARD_EN=0: regfile only, with read-before-write in the same cycle.

ALU (aluc):
- 0000 A'
- 0001 B
- 0011 ~B
- 0100 A'+B, CY = carry-out
- 0101 A'+B+CY, CY = carry-out
- 0110 A'|B
- 0111 A'&B
- 1000 A'^B
- 1001 A'-B, CY = borrow
- 1011 CY=0, no write
- 1100 CY=1, no write
- Other codes: NOP (no write, CY unchanged, print ignored).
- CY read by 0101 is the value after the preceding op's E1, so there is no carry hazard.

Shifter (sh, applied after ALU; CY unaffected):
- 000 none
- 001 shl1
- 010 lsr1
- 011 shl DATA_W/2
- 100 lsr DATA_W/2
- 101 rol1
- 110 ror1
- 111 asr1

Arithmetic: modulo 2**DATA_W.

Fields read, write, flip: ignored here.

Decomposition:
- Package ev21g1_pkg: aluc opcode constants, sh code constants, uinstr field offsets as functions of REG_ADDR_W, null-address function.
- Sub-module ev21g1_alu_shift: combinational ALU plus shifter with carry in/out.
- Regfile and forwarding stay in the top module.

Test Plan:
1. Back-to-back dependency, FORWARD_EN=1, no NOPs.
   - Stimulus: R1=K 5; R2=R1+R1; R3=R2|R1 (print).
   - Expect: out_data=0x0000000F two cycles after the last issue.
2. Carry chain, no NOPs.
   - Stimulus: R24=0x8000 sh=011; R23=0xFFFF sh=011; R23=K 0xFFFF | R23; R25=R24+R23 (print).
   - Expect: out_data=0x7FFFFFFF, cy=1.
3. STC then ADC.
   - Stimulus: STC; R3=K 3; R13=~R3; R20=R3+R13+CY (print).
   - Expect: out_data=0, cy=1.
   - Then CLC -> cy=0 one cycle after its E0.
4. Null destination.
   - Stimulus: c=all-ones with aluc=0000 k=0xABCD.
   - Expect: no register changes (verify by printing R0..R3 = prior values).
5. FORWARD_EN=0 instance.
   - Stimulus: R1=K 7; then immediately R2=R1 (print).
   - Expect: out_data=0 (stale).
   - With 2 NOPs inserted: expect out_data=7.
6. Reset mid-flight.
   - Stimulus: assert rst_n=0 one cycle after issuing R5=K 9 with print=1.
   - Expect: out_valid never pulses, and R5 reads 0 after release.
